// File: rtl/pass_sequencer.sv
// Runs one scheduler pass as a fixed sequence of data-movement transfers
// (filters, ifmaps, bias/psums, compute, psum writeback) on a req/ack channel.
module pass_sequencer #(
    parameter int C_WIDTH = 10,
    parameter int M_WIDTH = 10,   // also the width of the id outputs; must be >= C_WIDTH and N_WIDTH
    parameter int N_WIDTH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pass_start,
    output logic               pass_ready,
    output logic               pass_done,
    input  logic               bias_sel,
    input  logic [M_WIDTH-1:0] filter_lo,
    input  logic [M_WIDTH-1:0] filter_hi,
    input  logic [C_WIDTH-1:0] channel_lo,
    input  logic [C_WIDTH-1:0] channel_hi,
    input  logic [N_WIDTH-1:0] ifmap_lo,
    input  logic [N_WIDTH-1:0] ifmap_hi,
    output logic               xfer_req,
    output logic [2:0]         xfer_type,
    output logic [M_WIDTH-1:0] xfer_id_a,
    output logic [M_WIDTH-1:0] xfer_id_b,
    input  logic               xfer_ack,
    output logic               compute_start,
    input  logic               compute_done
);

    localparam logic [2:0] XT_FILT    = 3'd0;
    localparam logic [2:0] XT_IFMAP   = 3'd1;
    localparam logic [2:0] XT_BIAS    = 3'd2;
    localparam logic [2:0] XT_PSUM_RD = 3'd3;
    localparam logic [2:0] XT_PSUM_WR = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FILT,
        LOAD_IFMAP,
        LOAD_PSUM,
        COMPUTE,
        WAIT_COMPUTE,
        WRITE_PSUM,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [M_WIDTH-1:0] outer_q, outer_d;
    logic [M_WIDTH-1:0] inner_q, inner_d;
    logic [M_WIDTH-1:0] f_lo_q, f_hi_q;
    logic [C_WIDTH-1:0] c_lo_q, c_hi_q;
    logic [N_WIDTH-1:0] n_lo_q, n_hi_q;
    logic               bias_q;

    logic               start_accept;
    logic [M_WIDTH-1:0] f_lo, f_hi, c_lo, c_hi, n_lo, n_hi;
    logic               bias;
    logic               f_empty, c_empty, n_empty;
    logic               filt_empty, ifm_empty, psum_empty, wr_empty;
    logic [M_WIDTH-1:0] out_hi, in_lo, in_hi;
    logic               bias_phase, inner_last;
    logic               enter;
    state_t             enter_s;

    assign start_accept = (state_q == IDLE) && pass_start;

    // In IDLE the ranges come straight from the ports so the first non-empty
    // phase can be selected in the same cycle pass_start is seen.
    always_comb begin
        if (state_q == IDLE) begin
            f_lo = filter_lo;
            f_hi = filter_hi;
            c_lo = M_WIDTH'(channel_lo);
            c_hi = M_WIDTH'(channel_hi);
            n_lo = M_WIDTH'(ifmap_lo);
            n_hi = M_WIDTH'(ifmap_hi);
            bias = bias_sel;
        end else begin
            f_lo = f_lo_q;
            f_hi = f_hi_q;
            c_lo = M_WIDTH'(c_lo_q);
            c_hi = M_WIDTH'(c_hi_q);
            n_lo = M_WIDTH'(n_lo_q);
            n_hi = M_WIDTH'(n_hi_q);
            bias = bias_q;
        end
    end

    assign f_empty    = f_hi < f_lo;
    assign c_empty    = c_hi < c_lo;
    assign n_empty    = n_hi < n_lo;
    assign filt_empty = f_empty | c_empty;
    assign ifm_empty  = n_empty | c_empty;
    assign psum_empty = bias ? f_empty : (n_empty | f_empty);
    assign wr_empty   = n_empty | f_empty;

    // Loop bounds of the phase currently being issued.
    always_comb begin
        out_hi     = '0;
        in_lo      = '0;
        in_hi      = '0;
        bias_phase = 1'b0;
        case (state_q)
            LOAD_FILT: begin
                out_hi = f_hi;
                in_lo  = c_lo;
                in_hi  = c_hi;
            end
            LOAD_IFMAP: begin
                out_hi = n_hi;
                in_lo  = c_lo;
                in_hi  = c_hi;
            end
            LOAD_PSUM: begin
                if (bias) begin
                    out_hi     = f_hi;
                    bias_phase = 1'b1;
                end else begin
                    out_hi = n_hi;
                    in_lo  = f_lo;
                    in_hi  = f_hi;
                end
            end
            WRITE_PSUM: begin
                out_hi = n_hi;
                in_lo  = f_lo;
                in_hi  = f_hi;
            end
            default: ;
        endcase
    end

    // Bias loads iterate over filters only, so the inner loop is always at its end.
    assign inner_last = bias_phase || (inner_q == in_hi);

    always_comb begin
        state_d = state_q;
        outer_d = outer_q;
        inner_d = inner_q;
        enter   = 1'b0;
        enter_s = IDLE;
        case (state_q)
            IDLE: begin
                if (pass_start) begin
                    enter   = 1'b1;
                    enter_s = LOAD_FILT;
                end
            end
            LOAD_FILT, LOAD_IFMAP, LOAD_PSUM, WRITE_PSUM: begin
                if (xfer_ack) begin
                    if (!inner_last) begin
                        inner_d = inner_q + 1'b1;
                    end else if (outer_q != out_hi) begin
                        outer_d = outer_q + 1'b1;
                        inner_d = in_lo;
                    end else begin
                        enter = 1'b1;
                        case (state_q)
                            LOAD_FILT:  enter_s = LOAD_IFMAP;
                            LOAD_IFMAP: enter_s = LOAD_PSUM;
                            LOAD_PSUM:  enter_s = COMPUTE;
                            default:    enter_s = DONE;
                        endcase
                    end
                end
            end
            COMPUTE:      state_d = WAIT_COMPUTE;
            WAIT_COMPUTE: begin
                if (compute_done) begin
                    enter   = 1'b1;
                    enter_s = WRITE_PSUM;
                end
            end
            DONE:         state_d = IDLE;
            default:      state_d = IDLE;
        endcase

        // Empty phases fall through in order within this one evaluation.
        if (enter) begin
            if (enter_s == LOAD_FILT && filt_empty) enter_s = LOAD_IFMAP;
            if (enter_s == LOAD_IFMAP && ifm_empty) enter_s = LOAD_PSUM;
            if (enter_s == LOAD_PSUM && psum_empty) enter_s = COMPUTE;
            if (enter_s == WRITE_PSUM && wr_empty) enter_s = DONE;
            state_d = enter_s;
            case (enter_s)
                LOAD_FILT: begin
                    outer_d = f_lo;
                    inner_d = c_lo;
                end
                LOAD_IFMAP: begin
                    outer_d = n_lo;
                    inner_d = c_lo;
                end
                LOAD_PSUM: begin
                    outer_d = bias ? f_lo : n_lo;
                    inner_d = bias ? '0 : f_lo;
                end
                WRITE_PSUM: begin
                    outer_d = n_lo;
                    inner_d = f_lo;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            outer_q <= '0;
            inner_q <= '0;
            f_lo_q  <= '0;
            f_hi_q  <= '0;
            c_lo_q  <= '0;
            c_hi_q  <= '0;
            n_lo_q  <= '0;
            n_hi_q  <= '0;
            bias_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            outer_q <= outer_d;
            inner_q <= inner_d;
            if (start_accept) begin
                f_lo_q <= filter_lo;
                f_hi_q <= filter_hi;
                c_lo_q <= channel_lo;
                c_hi_q <= channel_hi;
                n_lo_q <= ifmap_lo;
                n_hi_q <= ifmap_hi;
                bias_q <= bias_sel;
            end
        end
    end

    // Outputs decode the state register only, so an async reset drops xfer_req at once.
    always_comb begin
        xfer_req  = 1'b0;
        xfer_type = XT_FILT;
        xfer_id_a = '0;
        xfer_id_b = '0;
        case (state_q)
            LOAD_FILT: begin
                xfer_req  = 1'b1;
                xfer_type = XT_FILT;
                xfer_id_a = outer_q;
                xfer_id_b = inner_q;
            end
            LOAD_IFMAP: begin
                xfer_req  = 1'b1;
                xfer_type = XT_IFMAP;
                xfer_id_a = outer_q;
                xfer_id_b = inner_q;
            end
            LOAD_PSUM: begin
                xfer_req  = 1'b1;
                xfer_type = bias_q ? XT_BIAS : XT_PSUM_RD;
                xfer_id_a = outer_q;
                xfer_id_b = bias_q ? '0 : inner_q;
            end
            WRITE_PSUM: begin
                xfer_req  = 1'b1;
                xfer_type = XT_PSUM_WR;
                xfer_id_a = outer_q;
                xfer_id_b = inner_q;
            end
            default: ;
        endcase
    end

    assign pass_ready    = (state_q == IDLE);
    assign compute_start = (state_q == COMPUTE);
    assign pass_done     = (state_q == DONE);

endmodule
